// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive-side token controller.
// The optional inter-bit timeout is enabled by defining TOKEN_TIMEOUT_EN.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_FIELD,
        ST_CRC,
        ST_WAIT_EOP
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_CRC   = 2'b01,
        ERR_LEN   = 2'b10,
        ERR_ABORT = 2'b11
    } err_code_t;

    localparam int ADDR_W           = 7;
    localparam int ENDP_W           = 4;
    localparam int TOKEN_FIELD_BITS = 11;
    localparam int CRC5_BITS        = 5;
    localparam int BIT_CNT_W        = 4;

    localparam logic [CRC5_BITS-1:0] CRC5_RESIDUAL_DEFAULT  = 5'b01100;
    localparam int                   TIMEOUT_CYCLES_DEFAULT = 64;

endpackage

// File: rtl/usb_token_bit_counter.sv
// Small bit counter used to delimit the token field and the CRC5 field.
// term_hit compares the current count against a caller-supplied terminal value.
module usb_token_bit_counter
    import usb_rx_pkg::*;
(
    input  logic                 clk,
    input  logic                 sync_rst,
    input  logic                 clear,
    input  logic                 inc,
    input  logic [BIT_CNT_W-1:0] term,
    output logic [BIT_CNT_W-1:0] count,
    output logic                 term_hit
);

    always_ff @(posedge clk) begin
        if (sync_rst || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign term_hit = (count == term);

endmodule

// File: rtl/usb_token_crc5_ctrl.sv
// Sequences the external CRC5 engine over a USB token and reports a one-cycle verdict.
// Define TOKEN_TIMEOUT_EN to abort packets that stall longer than TIMEOUT_CYCLES between bits.
// Handshake: all inputs are single-cycle strobes sampled at posedge clk; verdict outputs
// (token_valid/token_err) are registered one-cycle pulses with no backpressure.
module usb_token_crc5_ctrl
  import usb_rx_pkg::*;
#(
  parameter logic [CRC5_BITS-1:0] CRC5_RESIDUAL  = CRC5_RESIDUAL_DEFAULT,
  parameter int                   TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 sync_rst,
  input  logic                 pid_token,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 eop,
  input  logic                 rcv_error,
  input  logic [CRC5_BITS-1:0] crc_value,
  output logic                 crc_sync_rst,
  output logic                 crc_shift_enable,
  output logic                 crc_rcv,
  output logic                 crc_shift_stop,
  output logic [ADDR_W-1:0]    token_addr,
  output logic [ENDP_W-1:0]    token_endp,
  output logic                 token_valid,
  output logic                 token_err,
  output logic [1:0]           err_code,
  output logic                 busy,
  output state_t               fsm_state
);

  state_t                state;
  state_t                state_next;
  err_code_t             err_next;
  logic                  verdict_ok;
  logic                  verdict_err;
  logic                  start;
  logic                  capture;
  logic                  cnt_clear;
  logic                  cnt_inc;
  logic [BIT_CNT_W-1:0]  cnt_term;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  cnt_hit;
  logic                  timeout_hit;

  usb_token_bit_counter u_bit_counter (
    .clk      (clk),
    .sync_rst (sync_rst),
    .clear    (cnt_clear),
    .inc      (cnt_inc),
    .term     (cnt_term),
    .count    (bit_cnt),
    .term_hit (cnt_hit)
  );

`ifdef TOKEN_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_expired;

  always_ff @(posedge clk) begin
    if (sync_rst || state == ST_IDLE || state == ST_INIT || bit_valid || eop) begin
      idle_cnt <= '0;
    end else if (!idle_expired) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign idle_expired = (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
  // Any real line activity this cycle takes precedence over the stall abort.
  assign timeout_hit  = idle_expired && !bit_valid && !eop && !rcv_error &&
                        (state == ST_FIELD || state == ST_CRC || state == ST_WAIT_EOP);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next       = state;
    err_next         = err_code_t'(err_code);
    verdict_ok       = 1'b0;
    verdict_err      = 1'b0;
    start            = 1'b0;
    capture          = 1'b0;
    cnt_clear        = 1'b0;
    cnt_inc          = 1'b0;
    cnt_term         = BIT_CNT_W'(TOKEN_FIELD_BITS - 1);
    crc_sync_rst     = 1'b0;
    crc_shift_enable = 1'b0;
    crc_rcv          = 1'b0;
    crc_shift_stop   = 1'b0;

    case (state)
      ST_IDLE: begin
        crc_shift_stop = 1'b1;
        if (pid_token) begin
          state_next = ST_INIT;
          start      = 1'b1;
          err_next   = ERR_NONE;
        end
      end

      ST_INIT: begin
        crc_sync_rst = 1'b1;
        cnt_clear    = 1'b1;
        if (rcv_error) begin
          state_next  = ST_IDLE;
          verdict_err = 1'b1;
          err_next    = ERR_ABORT;
        end else if (bit_valid || eop) begin
          state_next  = ST_IDLE;
          verdict_err = 1'b1;
          err_next    = ERR_LEN;
        end else begin
          state_next = ST_FIELD;
        end
      end

      ST_FIELD, ST_CRC: begin
        crc_rcv          = 1'b1;
        // A bit sharing its cycle with eop or an abort is dropped, engine included.
        crc_shift_enable = bit_valid && !eop && !rcv_error;
        if (state == ST_CRC) begin
          cnt_term = BIT_CNT_W'(CRC5_BITS - 1);
        end
        if (rcv_error) begin
          state_next  = ST_IDLE;
          verdict_err = 1'b1;
          err_next    = ERR_ABORT;
        end else if (eop) begin
          state_next  = ST_IDLE;
          verdict_err = 1'b1;
          err_next    = ERR_LEN;
        end else if (bit_valid) begin
          capture = (state == ST_FIELD);
          if (cnt_hit) begin
            cnt_clear  = 1'b1;
            state_next = (state == ST_FIELD) ? ST_CRC : ST_WAIT_EOP;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end

      ST_WAIT_EOP: begin
        crc_shift_stop = 1'b1;
        if (rcv_error) begin
          state_next  = ST_IDLE;
          verdict_err = 1'b1;
          err_next    = ERR_ABORT;
        end else if (eop) begin
          state_next = ST_IDLE;
          if (crc_value == CRC5_RESIDUAL) begin
            verdict_ok = 1'b1;
          end else begin
            verdict_err = 1'b1;
            err_next    = ERR_CRC;
          end
        end else if (bit_valid) begin
          state_next  = ST_IDLE;
          verdict_err = 1'b1;
          err_next    = ERR_LEN;
        end
      end

      default: begin
        state_next     = ST_IDLE;
        crc_shift_stop = 1'b1;
      end
    endcase

    if (timeout_hit) begin
      state_next  = ST_IDLE;
      verdict_ok  = 1'b0;
      verdict_err = 1'b1;
      err_next    = ERR_ABORT;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state       <= ST_IDLE;
      token_valid <= 1'b0;
      token_err   <= 1'b0;
      err_code    <= ERR_NONE;
      token_addr  <= '0;
      token_endp  <= '0;
    end else begin
      state       <= state_next;
      token_valid <= verdict_ok;
      token_err   <= verdict_err;
      err_code    <= err_next;
      if (start) begin
        token_addr <= '0;
        token_endp <= '0;
      end else if (capture) begin
        // LSB-first: shifting in at the top leaves the first bit in position 0.
        if (bit_cnt < BIT_CNT_W'(ADDR_W)) begin
          token_addr <= {bit_in, token_addr[ADDR_W-1:1]};
        end else begin
          token_endp <= {bit_in, token_endp[ENDP_W-1:1]};
        end
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_usb_token_crc5_ctrl.sv
// Randomized scoreboard bench for usb_token_crc5_ctrl with a behavioural CRC5 engine
// and a packet-level reference model for the expected verdicts.
module tb_usb_token_crc5_ctrl;
  import usb_rx_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic sync_rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        pid_token = 1'b0, bit_valid = 1'b0, bit_in = 1'b0, eop = 1'b0, rcv_error = 1'b0;
  logic [4:0]  crc_value;
  logic        crc_sync_rst, crc_shift_enable, crc_rcv, crc_shift_stop;
  logic [6:0]  token_addr;
  logic [3:0]  token_endp;
  logic        token_valid, token_err, busy;
  logic [1:0]  err_code;
  state_t      fsm_state;

  usb_token_crc5_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk              (clk),
    .sync_rst         (sync_rst),
    .pid_token        (pid_token),
    .bit_valid        (bit_valid),
    .bit_in           (bit_in),
    .eop              (eop),
    .rcv_error        (rcv_error),
    .crc_value        (crc_value),
    .crc_sync_rst     (crc_sync_rst),
    .crc_shift_enable (crc_shift_enable),
    .crc_rcv          (crc_rcv),
    .crc_shift_stop   (crc_shift_stop),
    .token_addr       (token_addr),
    .token_endp       (token_endp),
    .token_valid      (token_valid),
    .token_err        (token_err),
    .err_code         (err_code),
    .busy             (busy),
    .fsm_state        (fsm_state)
  );

  // External CRC5 engine (x^5 + x^2 + 1, preset to all ones).
  logic [4:0] crc_eng = 5'h1F;
  always @(posedge clk) begin
    if (crc_sync_rst) crc_eng <= 5'h1F;
    else if (crc_shift_enable && crc_rcv)
      crc_eng <= {crc_eng[3:0], 1'b0} ^ ((crc_eng[4] ^ bit_in) ? 5'h05 : 5'h00);
  end
  assign crc_value = crc_eng;

  // ---------------- reference model ----------------
  // CRC5 a transmitter appends: remainder of the 11-bit field, inverted, sent MSB first.
  function automatic logic [4:0] crc5_tx(input logic [10:0] field);
    logic [4:0] r;
    r = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      if (r[4] ^ field[i]) r = {r[3:0], 1'b0} ^ 5'h05;
      else                 r = {r[3:0], 1'b0};
    end
    return ~r;
  endfunction

  // Wire order of a packet: 11 field bits, 5 CRC bits, one spare bit for overlong runs.
  function automatic logic [16:0] mk_bits(input logic [6:0] a, input logic [3:0] e,
                                          input logic [4:0] crc_xor);
    logic [16:0] b;
    logic [4:0]  c;
    b[10:0] = {e, a};
    c = crc5_tx({e, a}) ^ crc_xor;
    for (int j = 0; j < 5; j++) b[11 + j] = c[4 - j];
    b[16] = 1'($urandom_range(0, 1));
    return b;
  endfunction

  // ---------------- scoreboard ----------------
  // {chk_cyc, cyc[19:0], chk_ae, addr[6:0], endp[3:0], valid, err[1:0]}
  localparam int EXP_W = 36;
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int inv_bad = 0;

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic push_exp(input bit chk_cyc, input int vcyc, input bit chk_ae,
                          input logic [6:0] a, input logic [3:0] e,
                          input bit ok, input logic [1:0] err);
    exp_q.push_back({chk_cyc, 20'(vcyc), chk_ae, a, e, ok, err});
  endtask

  always @(negedge clk) begin
    logic [EXP_W-1:0] x;
    if (crc_shift_enable && crc_shift_stop) inv_bad++;
    if (crc_sync_rst && crc_shift_enable) inv_bad++;
    if (token_valid && token_err) inv_bad++;
    if (token_valid || token_err) begin
      if (exp_q.size() == 0) begin
        check("spurious_verdict", {token_valid, token_err}, 0);
      end else begin
        x = exp_q.pop_front();
        check("verdict_valid", token_valid, x[2]);
        check("verdict_err", token_err, !x[2]);
        check("err_code", err_code, x[1:0]);
        check("busy_at_verdict", busy, 0);
        if (x[35]) check("verdict_latency", cyc, x[34:15]);
        if (x[14]) begin
          check("token_addr", token_addr, x[13:7]);
          check("token_endp", token_endp, x[6:3]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit pv, input bit bv, input bit b, input bit e, input bit re);
    @(posedge clk);
    #1;
    pid_token = pv; bit_valid = bv; bit_in = b; eop = e; rcv_error = re;
  endtask

  task automatic start_packet();
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("err_cleared_on_pid", err_code, 0);
    check("busy_after_pid", busy, 1);
  endtask

  // abort_at < 0: no abort. eop_with_last: final bit shares its cycle with eop.
  task automatic send_packet(input logic [16:0] bits, input int nbits, input int abort_at,
                             input bit eop_with_last, input bit noisy_pid);
    int         n_eff;
    bit         done;
    logic [1:0] exp_err;
    logic [4:0] sent;
    bit         ok;
    n_eff = 0;
    done  = 0;
    exp_err = ERR_NONE;
    start_packet();
    for (int i = 0; i < nbits && !done; i++) begin
      repeat ($urandom_range(0, 2)) drive(noisy_pid && ($urandom_range(0, 3) == 0), 0, 0, 0, 0);
      if (i == abort_at) begin
        drive(0, 1, bits[i], 1'($urandom_range(0, 1)), 1);
        exp_err = ERR_ABORT;
        push_exp(1, cyc + 1, 0, 0, 0, 0, exp_err);
        done = 1;
      end else if (eop_with_last && i == nbits - 1) begin
        drive(0, 1, bits[i], 1, 0);
        exp_err = ERR_LEN;
        push_exp(1, cyc + 1, 0, 0, 0, 0, exp_err);
        done = 1;
      end else begin
        drive(0, 1, bits[i], 0, 0);
        n_eff++;
        if (n_eff == 17) begin
          exp_err = ERR_LEN;
          push_exp(1, cyc + 1, 0, 0, 0, 0, exp_err);
          done = 1;
        end
      end
    end
    if (!done) begin
      repeat ($urandom_range(0, 2)) drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0);
      if (n_eff != 16) begin
        exp_err = ERR_LEN;
        push_exp(1, cyc + 1, 0, 0, 0, 0, exp_err);
      end else begin
        for (int j = 0; j < 5; j++) sent[4 - j] = bits[11 + j];
        ok = (sent == crc5_tx(bits[10:0]));
        exp_err = ok ? ERR_NONE : ERR_CRC;
        push_exp(1, cyc + 1, 1, bits[6:0], bits[10:7], ok, exp_err);
      end
    end else if (n_eff == 17) begin
      drive(0, 0, 0, 1, 0);
    end
    repeat (3) drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("err_code_held", err_code, exp_err);
    check("idle_after_packet", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [16:0] b;
    int          kind;

    repeat (3) @(posedge clk);
    #1 sync_rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_token_valid", token_valid, 0);
    check("rst_token_err", token_err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_shift_stop", crc_shift_stop, 1);
    check("rst_shift_enable", crc_shift_enable, 0);
    check("rst_crc_rcv", crc_rcv, 0);

    // Inputs other than pid_token are ignored while idle.
    drive(0, 1, 1, 1, 1);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("idle_ignores_inputs", busy, 0);

    send_packet(mk_bits(7'h3A, 4'h1, 5'b00000), 16, -1, 0, 0);
    send_packet(mk_bits(7'h3A, 4'h1, 5'b00100), 16, -1, 0, 0);
    send_packet(mk_bits(7'h55, 4'hA, 5'b00000), 12, -1, 0, 0);
    send_packet(mk_bits(7'h12, 4'h7, 5'b00000), 17, -1, 0, 0);
    send_packet(mk_bits(7'h01, 4'h2, 5'b00000), 16, 6, 0, 0);
    send_packet(mk_bits(7'h7F, 4'hF, 5'b00000), 16, -1, 1, 0);

    // Reset in the middle of the field: back to idle, no verdict.
    b = mk_bits(7'h2C, 4'h3, 5'b00000);
    start_packet();
    for (int i = 0; i < 9; i++) drive(0, 1, b[i], 0, 0);
    @(posedge clk);
    #1 sync_rst = 1'b1; bit_valid = 1'b1; bit_in = b[9];
    @(posedge clk);
    #1 sync_rst = 1'b0; bit_valid = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_err_code", err_code, 0);
    check("midrst_addr", token_addr, 0);
    repeat (4) drive(0, 0, 0, 0, 0);

    // Stall after five bits.
    b = mk_bits(7'h44, 4'h5, 5'b00000);
    start_packet();
    for (int i = 0; i < 5; i++) drive(0, 1, b[i], 0, 0);
`ifdef TOKEN_TIMEOUT_EN
    push_exp(0, 0, 0, 0, 0, 0, ERR_ABORT);
    repeat (20) drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("timeout_idle", busy, 0);
    check("timeout_err_code", err_code, ERR_ABORT);
`else
    repeat (20) drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("stall_still_busy", busy, 1);
    drive(0, 0, 0, 0, 1);
    push_exp(1, cyc + 1, 0, 0, 0, 0, ERR_ABORT);
    repeat (3) drive(0, 0, 0, 0, 0);
`endif

    // Randomized packets.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      b = mk_bits(7'($urandom), 4'($urandom),
                  (kind == 5) ? 5'(1 << $urandom_range(0, 4)) : 5'b00000);
      case (kind)
        6:       send_packet(b, $urandom_range(0, 15), -1, 0, 1);
        7:       send_packet(b, 17, -1, 0, 1);
        8:       send_packet(b, 16, -1, 1, 1);
        9:       send_packet(b, 16, $urandom_range(0, 15), 0, 1);
        default: send_packet(b, 16, -1, 0, 1);
      endcase
    end

    repeat (5) drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("crc_ctrl_invariants", inv_bad, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/usb_token_crc5_ctrl.md
Name: usb_token_crc5_ctrl

Overview:
- Receive-side controller that sequences the 5-bit CRC checker for USB token packets (OUT/IN/SETUP/SOF).
- Starts when the PID decoder flags a token PID. Drives the CRC engine's sync reset, shift and receive controls across the 11-bit field and the 5-bit CRC, and captures ADDR/ENDP.
- At EOP, compares the CRC engine residual and emits a one-cycle valid or error verdict to the Rx packet FSM.

Parameters:
- CRC5_RESIDUAL, 5'b01100, expected engine state after a good field+CRC.
- TIMEOUT_CYCLES, 64, inter-bit idle limit; used only with TOKEN_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- sync_rst  in  1  synchronous active-high reset
- pid_token  in  1  one-cycle pulse: token PID decoded
- bit_valid  in  1  one-cycle strobe: unstuffed bit on bit_in
- bit_in  in  1  received data bit, LSB first
- eop  in  1  one-cycle end-of-packet pulse
- rcv_error  in  1  line/stuff error abort
- crc_value  in  5  current CRC engine state (registered)
- crc_sync_rst  out  1  CRC engine reinitialise to 5'b11111
- crc_shift_enable  out  1  CRC engine shift strobe
- crc_rcv  out  1  CRC engine accumulate enable
- crc_shift_stop  out  1  CRC engine hold
- token_addr  out  7  captured address
- token_endp  out  4  captured endpoint
- token_valid  out  1  one-cycle pulse: good token
- token_err  out  1  one-cycle pulse: bad token
- err_code  out  2  00 none, 01 crc, 10 length, 11 abort/timeout; held until next pid_token
- busy  out  1  high in any state but IDLE

Behaviour:
- Reset (sync_rst high at posedge): state IDLE; all outputs 0 except crc_shift_stop=1; bit_cnt=0. Applies mid-packet too; no verdict is pulsed.
- IDLE: crc_shift_stop=1.
  - pid_token -> INIT; clear err_code, token_addr, token_endp.
  - bit_valid, eop and rcv_error are ignored.
- INIT (exactly 1 cycle): crc_sync_rst=1, crc_shift_stop=0 -> FIELD; bit_cnt=0.
  - Bits arriving in INIT are not expected; a bit_valid here is a length error -> ERR.
- FIELD: crc_rcv=1, crc_shift_enable=bit_valid.
  - Each bit_valid shifts bit_in into {endp,addr} LSB-first: bits 0-6 go to addr, bits 7-10 go to endp.
  - bit_cnt increments. On the 11th bit -> CRC with bit_cnt=0.
- CRC: crc_rcv=1, crc_shift_enable=bit_valid. After the 5th bit -> WAIT_EOP.
- WAIT_EOP: crc_shift_stop=1.
  - eop: token_valid=1 if crc_value==CRC5_RESIDUAL, else token_err=1 with err_code=01. Go to IDLE.
  - bit_valid before eop: token_err, err_code=10 -> IDLE.
- eop in FIELD/CRC: err_code=10, token_err -> IDLE.
- eop coinciding with bit_valid: eop wins and the bit is dropped. In CRC this means the 16th bit coinciding with eop is a length error.
- rcv_error in any non-IDLE state: next cycle token_err, err_code=11 -> IDLE. It has priority over eop and bit_valid.
- Verdict latency: token_valid/token_err are asserted in the cycle after eop is sampled (registered). crc_value is compared the cycle eop is sampled; it is stable because the last shift was at least one cycle earlier.
- Exactly one of token_valid/token_err per packet; never both.
- pid_token while busy is ignored.
- CRC engine outputs obey: crc_shift_enable is never high with crc_shift_stop; crc_sync_rst is never high with crc_shift_enable.

Optional Feature:
- Macro: TOKEN_TIMEOUT_EN.
- Defined: idle counter resets on every bit_valid and on entry to INIT. In FIELD/CRC/WAIT_EOP, reaching TIMEOUT_CYCLES with no bit_valid/eop gives token_err, err_code=11 -> IDLE.
- Undefined: no counter; the controller waits indefinitely (only sync_rst, rcv_error or eop exit).

Decomposition:
- Package usb_rx_pkg: state enum (IDLE, INIT, FIELD, CRC, WAIT_EOP), err_code enum, ADDR_W=7, ENDP_W=4, TOKEN_FIELD_BITS=11, CRC5_BITS=5, default CRC5_RESIDUAL.
- One sub-module: usb_token_bit_counter, a 4-bit counter with clear, increment and terminal-count compare. The CRC engine itself stays external.

Test Plan:
- Reset values: hold sync_rst 3 cycles -> busy=0, token_valid=0, err_code=00, crc_shift_stop=1.
- Good OUT token: pid_token, addr=7'h3A, endp=4'h1, correct CRC5 from the model, eop -> token_addr=7'h3A, token_endp=4'h1, one token_valid pulse 1 cycle after eop, err_code=00.
- Corrupted CRC: same packet with CRC bit 2 flipped -> token_err pulse, err_code=01, no token_valid.
- Short packet: eop after 12 bits -> token_err, err_code=10. Long packet: 17 bits then eop -> token_err, err_code=10.
- Abort and reset: rcv_error at bit 6 -> token_err, err_code=11, IDLE next cycle. A separate run with sync_rst at bit 9 -> IDLE, no verdict pulse.
- With TOKEN_TIMEOUT_EN and TIMEOUT_CYCLES=8: stall 8 cycles after bit 4 -> token_err, err_code=11. Without the macro, the same stall keeps busy=1.
